// File: rtl/nonce_sweep.sv
// Nonce-search controller feeding a double-SHA256 hasher: issues one header per nonce,
// compares each returned digest against the target, stops on first hit or range end.
module nonce_sweep #(
    parameter bit NONCE_LE   = 1'b1,
    parameter bit DIGEST_REV = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [607:0] header_tmpl,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic [639:0] hdr_out,
    output logic         hdr_valid,
    input  logic         hdr_ready,
    input  logic [255:0] digest_in,
    input  logic         digest_valid,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_digest,
    output logic [31:0]  attempts,
    output logic [2:0]   state_dbg
);

    // Handshake: a header transfers on any rising edge where hdr_valid and hdr_ready are
    // both high; hdr_out never changes while hdr_valid is high. digest_valid is a one-cycle
    // strobe and is only consumed while waiting for the outstanding header's digest.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [255:0] brev256(input logic [255:0] v);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i*8 +: 8] = v[(31-i)*8 +: 8];
        end
        return r;
    endfunction

    state_t         state_q, state_d;
    logic [607:0]   tmpl_q, tmpl_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    nonce_end_q, nonce_end_d;
    logic [255:0]   target_q, target_d;
    logic [255:0]   digest_q, digest_d;
    logic [31:0]    attempts_q, attempts_d;
    logic           found_q, found_d;
    logic           exhausted_q, exhausted_d;
    logic [31:0]    found_nonce_q, found_nonce_d;
    logic [255:0]   found_digest_q, found_digest_d;
    logic           done_q, done_d;
    logic           hdr_valid_q, hdr_valid_d;
    logic           busy_q, busy_d;
    logic [255:0]   cmp_val;
    logic           hit;

    always_comb begin
        cmp_val = DIGEST_REV ? brev256(digest_q) : digest_q;
        hit     = (cmp_val <= target_q);
    end

    always_comb begin
        state_d        = state_q;
        tmpl_d         = tmpl_q;
        nonce_d        = nonce_q;
        nonce_end_d    = nonce_end_q;
        target_d       = target_q;
        digest_d       = digest_q;
        attempts_d     = attempts_q;
        found_d        = found_q;
        exhausted_d    = exhausted_q;
        found_nonce_d  = found_nonce_q;
        found_digest_d = found_digest_q;
        done_d         = 1'b0;

        if (abort) begin
            state_d     = S_IDLE;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        tmpl_d      = header_tmpl;
                        nonce_d     = nonce_start;
                        nonce_end_d = nonce_end;
                        target_d    = target;
                        attempts_d  = 32'd0;
                        found_d     = 1'b0;
                        exhausted_d = 1'b0;
                        state_d     = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (hdr_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (digest_valid) begin
                        digest_d   = digest_in;
                        attempts_d = attempts_q + 32'd1;
                        state_d    = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (hit) begin
                        found_d        = 1'b1;
                        found_nonce_d  = nonce_q;
                        found_digest_d = digest_q;
                        done_d         = 1'b1;
                        state_d        = S_DONE;
                    end else if (nonce_q == nonce_end_q) begin
                        // Equality test (not <=) makes wrapped ranges sweep through 0.
                        exhausted_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        nonce_d = nonce_q + 32'd1;
                        state_d = S_ISSUE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        hdr_valid_d = (state_d == S_ISSUE);
        busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            tmpl_q         <= '0;
            nonce_q        <= '0;
            nonce_end_q    <= '0;
            target_q       <= '0;
            digest_q       <= '0;
            attempts_q     <= '0;
            found_q        <= 1'b0;
            exhausted_q    <= 1'b0;
            found_nonce_q  <= '0;
            found_digest_q <= '0;
            done_q         <= 1'b0;
            hdr_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmpl_q         <= tmpl_d;
            nonce_q        <= nonce_d;
            nonce_end_q    <= nonce_end_d;
            target_q       <= target_d;
            digest_q       <= digest_d;
            attempts_q     <= attempts_d;
            found_q        <= found_d;
            exhausted_q    <= exhausted_d;
            found_nonce_q  <= found_nonce_d;
            found_digest_q <= found_digest_d;
            done_q         <= done_d;
            hdr_valid_q    <= hdr_valid_d;
            busy_q         <= busy_d;
        end
    end

    // Header is built from registered template and nonce, so it only moves on start or nonce step.
    assign hdr_out      = {tmpl_q, (NONCE_LE ? bswap32(nonce_q) : nonce_q)};
    assign hdr_valid    = hdr_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign found_nonce  = found_nonce_q;
    assign found_digest = found_digest_q;
    assign attempts     = attempts_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_nonce_sweep.sv
// Bench for nonce_sweep: hasher stub, transaction-level sweep model with a per-cycle
// monitor, and directed scenarios with hand-computed literal expectations.
module tb_nonce_sweep;

    localparam logic [639:0] GEN_HDR = {
        32'h01000000,
        256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
    localparam logic [255:0] GEN_DIG =
        256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [255:0] GEN_DISP =
        256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] GEN_TGT = {32'h0, 32'hffff0000, 192'h0};

    logic         clk = 1'b0;
    logic         rst, start, abort, hdr_ready;
    logic [607:0] header_tmpl;
    logic [31:0]  nonce_start, nonce_end;
    logic [255:0] target;
    logic [639:0] hdr_out;
    logic         hdr_valid, busy, done, found, exhausted;
    logic [255:0] digest_in;
    logic         digest_valid;
    logic [31:0]  found_nonce, attempts;
    logic [255:0] found_digest;
    logic [2:0]   state_dbg;

    logic         stub_dv, spur_dv;
    logic [255:0] stub_dig, spur_dig;
    int           stub_lat;

    assign digest_valid = stub_dv | spur_dv;
    assign digest_in    = spur_dv ? spur_dig : stub_dig;

    always #5 clk = ~clk;

    nonce_sweep dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .header_tmpl(header_tmpl), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .target(target), .hdr_out(hdr_out), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .digest_in(digest_in), .digest_valid(digest_valid), .busy(busy), .done(done),
        .found(found), .exhausted(exhausted), .found_nonce(found_nonce),
        .found_digest(found_digest), .attempts(attempts), .state_dbg(state_dbg)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    int           done_cnt = 0;
    logic [639:0] exp_q[$];
    logic [31:0]  nonce_log[$];
    logic         exp_found, exp_exh;
    logic [31:0]  exp_nonce, exp_attempts;
    logic [255:0] exp_dig;
    logic [607:0] tmpl_a;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [255:0] rev256(input logic [255:0] v);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[i*8 +: 8] = v[(31-i)*8 +: 8];
        return r;
    endfunction

    // Hasher stand-in: genesis header yields the real genesis digest; anything else
    // yields a digest whose display-order top byte is 0xFF (never below a small target).
    function automatic logic [255:0] stub_digest(input logic [639:0] h);
        if (h == GEN_HDR) return GEN_DIG;
        return {h[247:0], 8'hff};
    endfunction

    task automatic model_sweep(input logic [607:0] tmpl, input logic [31:0] ns,
                               input logic [31:0] ne, input logic [255:0] tgt);
        logic [31:0]  n;
        logic [639:0] h;
        logic [255:0] d;
        exp_q.delete();
        n = ns;
        exp_found = 1'b0; exp_exh = 1'b0; exp_attempts = 32'd0;
        exp_nonce = 32'd0; exp_dig = '0;
        for (int k = 0; k < 64; k++) begin
            h = {tmpl, bswap32(n)};
            exp_q.push_back(h);
            exp_attempts = exp_attempts + 32'd1;
            d = stub_digest(h);
            if (rev256(d) <= tgt) begin
                exp_found = 1'b1; exp_nonce = n; exp_dig = d;
                break;
            end
            if (n == ne) begin
                exp_exh = 1'b1;
                break;
            end
            n = n + 32'd1;
        end
    endtask

    task automatic stub_proc();
        logic         pend;
        int           cnt;
        logic [639:0] h;
        pend = 1'b0; cnt = 0; h = '0;
        forever begin
            @(negedge clk);
            if (hdr_valid && hdr_ready) begin
                pend = 1'b1; cnt = stub_lat; h = hdr_out;
            end
            @(posedge clk);
            #1;
            stub_dv = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    stub_dv = 1'b1; stub_dig = stub_digest(h); pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    endtask

    task automatic monitor();
        logic         prev_stall;
        logic [639:0] prev_hdr;
        logic [639:0] e;
        prev_stall = 1'b0; prev_hdr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall) begin
                    check("stall_valid_held", hdr_valid, 1);
                    check("stall_hdr_stable", hdr_out, prev_hdr);
                end
                if (hdr_valid && hdr_ready) begin
                    check("xfer_expected", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("xfer_hdr", hdr_out, e);
                    end
                    nonce_log.push_back(bswap32(hdr_out[31:0]));
                end
                if (done) begin
                    done_cnt++;
                    check("done_found", found, exp_found);
                    check("done_exhausted", exhausted, exp_exh);
                    check("done_attempts", attempts, exp_attempts);
                    check("done_no_pending_xfer", exp_q.size(), 0);
                    if (exp_found) begin
                        check("done_found_nonce", found_nonce, exp_nonce);
                        check("done_found_digest", found_digest, exp_dig);
                    end
                end
            end
            prev_stall = hdr_valid && !hdr_ready;
            prev_hdr   = hdr_out;
        end
    endtask

    task automatic do_start(input logic [607:0] tmpl, input logic [31:0] ns,
                            input logic [31:0] ne, input logic [255:0] tgt);
        model_sweep(tmpl, ns, ne, tgt);
        nonce_log.delete();
        @(posedge clk); #1;
        header_tmpl = tmpl; nonce_start = ns; nonce_end = ne; target = tgt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1);
    endtask

    task automatic wait_dv(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (digest_valid) seen = 1'b1;
        end
        check({name, "_digest_seen"}, seen, 1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_hdr_out"}, hdr_out, 0);
        check({name, "_hdr_valid"}, hdr_valid, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_found"}, found, 0);
        check({name, "_exhausted"}, exhausted, 0);
        check({name, "_found_nonce"}, found_nonce, 0);
        check({name, "_found_digest"}, found_digest, 0);
        check({name, "_attempts"}, attempts, 0);
    endtask

    initial begin
        int           d0;
        logic [31:0]  lit_exh[4];
        logic [31:0]  lit_wrap[4];
        logic [607:0] gen_tmpl;
        bit           hs_seen;

        rst = 1'b1; start = 1'b0; abort = 1'b0; hdr_ready = 1'b1;
        header_tmpl = '0; nonce_start = '0; nonce_end = '0; target = '0;
        stub_dv = 1'b0; spur_dv = 1'b0; stub_dig = '0; spur_dig = '0; stub_lat = 2;
        exp_found = 1'b0; exp_exh = 1'b0; exp_nonce = '0; exp_attempts = '0; exp_dig = '0;
        for (int i = 0; i < 19; i++) tmpl_a[i*32 +: 32] = $urandom;
        lit_exh  = '{32'd5, 32'd6, 32'd7, 32'd8};
        lit_wrap = '{32'hffff_fffe, 32'hffff_ffff, 32'h0, 32'h1};
        gen_tmpl = GEN_HDR[639:32];

        fork
            stub_proc();
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Trivial target, single nonce, with cycle-exact timing.
        d0 = done_cnt;
        do_start(tmpl_a, 32'h10, 32'h20, '1);
        @(negedge clk);
        check("t1_valid_after_start", hdr_valid, 1);
        check("t1_busy_after_start", busy, 1);
        check("t1_hdr", hdr_out, {tmpl_a, 32'h1000_0000});
        wait_dv(20, "t1");
        @(negedge clk);
        check("t1_check_busy", busy, 1);
        check("t1_check_valid", hdr_valid, 0);
        check("t1_check_done", done, 0);
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_found", found, 1);
        check("t1_found_nonce", found_nonce, 32'h10);
        check("t1_attempts", attempts, 32'd1);
        @(negedge clk);
        check("t1_done_pulse_once", done, 0);
        check("t1_found_held", found, 1);
        check("t1_busy_done", busy, 0);
        check("t1_done_count", done_cnt - d0, 1);

        // Exhaustion; the next header follows a miss two cycles after digest_valid.
        do_start(tmpl_a, 32'd5, 32'd8, '0);
        wait_dv(20, "t2");
        @(negedge clk);
        @(negedge clk);
        check("t2_next_valid", hdr_valid, 1);
        check("t2_next_nonce_field", hdr_out[31:0], 32'h0600_0000);
        wait_done(100, "t2");
        check("t2_exhausted", exhausted, 1);
        check("t2_found", found, 0);
        check("t2_attempts", attempts, 32'd4);
        @(negedge clk);
        check("t2_xfer_count", nonce_log.size(), 4);
        for (int i = 0; i < 4 && i < nonce_log.size(); i++)
            check("t2_nonce_order", nonce_log[i], lit_exh[i]);

        // Wrap-around through 0xFFFFFFFF.
        do_start(tmpl_a, 32'hffff_fffe, 32'h1, '0);
        wait_done(100, "t3");
        check("t3_exhausted", exhausted, 1);
        check("t3_attempts", attempts, 32'd4);
        @(negedge clk);
        check("t3_xfer_count", nonce_log.size(), 4);
        for (int i = 0; i < 4 && i < nonce_log.size(); i++)
            check("t3_nonce_order", nonce_log[i], lit_wrap[i]);

        // Genesis header.
        do_start(gen_tmpl, 32'h7c2b_ac1b, 32'h7c2b_ac20, GEN_TGT);
        wait_done(100, "t4");
        check("t4_found", found, 1);
        check("t4_found_nonce", found_nonce, 32'h7c2b_ac1d);
        check("t4_hdr_nonce_field", hdr_out[31:0], 32'h1dac_2b7c);
        check("t4_digest_display", rev256(found_digest), GEN_DISP);
        check("t4_attempts", attempts, 32'd3);

        // Backpressure with a spurious digest during ISSUE.
        hdr_ready = 1'b0;
        do_start(tmpl_a, 32'h40, 32'h40, '1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_valid_held", hdr_valid, 1);
            check("t5_hdr_held", hdr_out, {tmpl_a, 32'h4000_0000});
            check("t5_attempts_held", attempts, 32'd0);
            @(posedge clk); #1;
            spur_dv = (k == 0);
            spur_dig = '0;
        end
        spur_dv = 1'b0;
        @(negedge clk);
        check("t5_spurious_ignored", attempts, 32'd0);
        @(posedge clk); #1;
        hdr_ready = 1'b1;
        wait_done(50, "t5");
        check("t5_found_nonce", found_nonce, 32'h40);
        check("t5_attempts", attempts, 32'd1);

        // Abort in WAIT; the late digest must be dropped.
        stub_lat = 4;
        d0 = done_cnt;
        do_start(tmpl_a, 32'd5, 32'd8, '0);
        hs_seen = 1'b0;
        for (int k = 0; k < 20 && !hs_seen; k++) begin
            @(negedge clk);
            if (hdr_valid && hdr_ready) hs_seen = 1'b1;
        end
        check("t6_handshake_seen", hs_seen, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_valid", hdr_valid, 0);
        check("t6_found", found, 0);
        check("t6_exhausted", exhausted, 0);
        wait_dv(20, "t6_late");
        repeat (3) @(negedge clk);
        check("t6_attempts", attempts, 32'd0);
        check("t6_busy_after_late", busy, 0);
        check("t6_no_done", done_cnt - d0, 0);
        stub_lat = 2;

        // Start in the same cycle as reset.
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        header_tmpl = tmpl_a; nonce_start = 32'h99; nonce_end = 32'h9a; target = '1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_all_zero("rst_start");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
